// File: rtl/module_light_scheduler.sv
// Two-button light scheduler: sync + debounce per button, round-robin grant
// of pending presses, and an OFF/ON power/scene FSM with an idle auto-off timer.
module module_light_scheduler #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 20000
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic       p1_pi,
  input  logic       p2_pi,
  output logic [2:0] b_po,
  output logic       on_po,
  output logic [1:0] grant_po
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // Index 0 = p1 (power), index 1 = p2 (scene)
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stable_d;
  logic [1:0]    stable_prev_q;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    press;

  logic [1:0]    pend_q, pend_d;
  logic          rr_last_q, rr_last_d;   // 0 = p1 won last tie, 1 = p2
  logic [1:0]    grant;

  state_t        state_q, state_d;
  logic [1:0]    scene_q, scene_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    b_q, b_d;
  logic          on_q, on_d;

  function automatic logic [2:0] scene_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    scene_pattern = 3'b001;
      2'd1:    scene_pattern = 3'b011;
      default: scene_pattern = 3'b111;
    endcase
  endfunction

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press = stable_q & ~stable_prev_q;
  end

  // Arbiter: single pending wins outright; on a tie the requester that did not win the last tie is served
  always_comb begin
    grant     = 2'b00;
    rr_last_d = rr_last_q;
    case (pend_q)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (rr_last_q) begin
          grant     = 2'b01;
          rr_last_d = 1'b0;
        end else begin
          grant     = 2'b10;
          rr_last_d = 1'b1;
        end
      end
      default: grant = 2'b00;
    endcase
    pend_d = (pend_q & ~grant) | press;
  end

  // Power/scene FSM with idle timer; a grant in the expiry cycle takes priority over timeout
  always_comb begin
    state_d = state_q;
    scene_d = scene_q;
    timer_d = timer_q;
    case (state_q)
      ST_OFF: begin
        timer_d = '0;
        if (grant[0]) begin
          state_d = ST_ON;
          timer_d = TMO_LOAD;
        end
      end
      ST_ON: begin
        if (grant[0]) begin
          state_d = ST_OFF;
          timer_d = '0;
        end else if (grant[1]) begin
          scene_d = (scene_q == 2'd2) ? 2'd0 : scene_q + 2'd1;
          timer_d = TMO_LOAD;
        end else if (timer_q == '0) begin
          state_d = ST_OFF;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    on_d = (state_d == ST_ON);
    b_d  = on_d ? scene_pattern(scene_d) : 3'b000;
  end

  // State registers
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q[0]      <= '0;
      cnt_q[1]      <= '0;
      pend_q        <= '0;
      rr_last_q     <= 1'b1;
      state_q       <= ST_OFF;
      scene_q       <= '0;
      timer_q       <= '0;
      b_q           <= '0;
      on_q          <= 1'b0;
    end else begin
      sync1_q       <= {p2_pi, p1_pi};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q[0]      <= cnt_d[0];
      cnt_q[1]      <= cnt_d[1];
      pend_q        <= pend_d;
      rr_last_q     <= rr_last_d;
      state_q       <= state_d;
      scene_q       <= scene_d;
      timer_q       <= timer_d;
      b_q           <= b_d;
      on_q          <= on_d;
    end
  end

  assign b_po     = b_q;
  assign on_po    = on_q;
  assign grant_po = grant;

endmodule

// File: tb/tb_module_light_scheduler.sv
// Bench for module_light_scheduler: scenario tasks plus a behavioural reference model.
module tb_module_light_scheduler;

  localparam int DEB = 8;
  localparam int T   = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;
  logic [2:0] b_po;
  logic       on_po;
  logic [1:0] grant_po;

  int n_chk  = 0;
  int n_fail = 0;

  module_light_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_pi  (clk),
    .rst_pi  (rst),
    .p1_pi   (p1),
    .p2_pi   (p2),
    .b_po    (b_po),
    .on_po   (on_po),
    .grant_po(grant_po)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample history window, pending flags, tie rotation, idle-cycle count
  logic [31:0] mh1 = '0, mh2 = '0;   // bit 0 = most recent raw sample
  logic        ms1 = 0, ms2 = 0;     // accepted levels
  logic        mr1 = 0, mr2 = 0;     // accepted level rose at last edge
  logic [1:0]  m_pend = '0;
  logic        m_rr = 1'b1;
  logic        m_on = 1'b0;
  int          m_scene = 0;
  int          m_idle = 0;
  logic [1:0]  m_grant = '0;
  logic [2:0]  m_b = '0;

  function automatic logic [1:0] arb(input logic [1:0] pend, input logic rr);
    if (pend == 2'b11) return rr ? 2'b01 : 2'b10;
    return pend;
  endfunction

  // Level flips when the DEB samples that reached the synchroniser output all differ from it
  function automatic logic flips(input logic [31:0] h, input logic st);
    for (int j = 1; j <= DEB; j++) if (h[j] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    logic n1, n2;
    if (rst) begin
      mh1 = '0; mh2 = '0; ms1 = 0; ms2 = 0; mr1 = 0; mr2 = 0;
      m_pend = '0; m_rr = 1'b1; m_on = 0; m_scene = 0; m_idle = 0;
    end else begin
      g = arb(m_pend, m_rr);
      if (m_pend == 2'b11) m_rr = g[1];
      if (m_on) begin
        if (g[0]) m_on = 0;
        else if (g[1]) begin m_scene = (m_scene + 1) % 3; m_idle = 0; end
        else begin
          m_idle++;
          if (m_idle == T) m_on = 0;
        end
      end else if (g[0]) begin
        m_on = 1; m_idle = 0;
      end
      m_pend = (m_pend & ~g) | {mr2, mr1};
      n1 = flips(mh1, ms1) ? ~ms1 : ms1;
      n2 = flips(mh2, ms2) ? ~ms2 : ms2;
      mr1 = n1 & ~ms1;
      mr2 = n2 & ~ms2;
      ms1 = n1; ms2 = n2;
      mh1 = {mh1[30:0], p1};
      mh2 = {mh2[30:0], p2};
    end
    m_grant = arb(m_pend, m_rr);
    m_b = m_on ? 3'((1 << (m_scene + 1)) - 1) : 3'b000;
  end

  task automatic test_reset();
    rst = 1; p1 = 0; p2 = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({grant_po, on_po, b_po} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got g=%b on=%b b=%b exp all 0", grant_po, on_po, b_po);
    end
    rst = 0;
  endtask

  task automatic test_power_on();
    int first = 0;
    p1 = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
        n_fail++;
        $display("FAIL power_model cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                 i, grant_po, on_po, b_po, m_grant, m_on, m_b);
      end
      if (grant_po != 0 && first == 0) first = i;
      if (i == 11) p1 = 0;
      if (i == 12) begin
        n_chk++;
        if (on_po !== 1'b1 || b_po !== 3'b001) begin
          n_fail++;
          $display("FAIL power_on_state got on=%b b=%b exp on=1 b=001", on_po, b_po);
        end
      end
    end
    n_chk++;
    if (first != DEB + 3) begin
      n_fail++;
      $display("FAIL power_grant_latency got %0d exp %0d", first, DEB + 3);
    end
  endtask

  task automatic test_glitch();
    int grants = 0;
    test_reset();
    p1 = 1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (i == 5) p1 = 0;
      n_chk++;
      if (grant_po !== 2'b00 || b_po !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch_no_grant cyc=%0d got g=%b b=%b exp g=00 b=000", i, grant_po, b_po);
      end
    end
    p1 = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_chk++;
      if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
        n_fail++;
        $display("FAIL bounce_model cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                 i, grant_po, on_po, b_po, m_grant, m_on, m_b);
      end
      if (grant_po != 0) grants++;
      p1 = (i == 1) ? 1'b0 : (i <= 14);
    end
    n_chk++;
    if (grants != 1 || on_po !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_one_grant got grants=%0d on=%b exp grants=1 on=1", grants, on_po);
    end
  endtask

  task automatic test_scene();
    logic [2:0] exp_b [3] = '{3'b011, 3'b111, 3'b001};
    for (int k = 0; k < 3; k++) begin
      int g = 0;
      p2 = 1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        n_chk++;
        if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
          n_fail++;
          $display("FAIL scene_model k=%0d cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                   k, i, grant_po, on_po, b_po, m_grant, m_on, m_b);
        end
        if (i == 12) p2 = 0;
        if (grant_po != 0 && g == 0) begin
          g = i;
          n_chk++;
          if (grant_po !== 2'b10) begin
            n_fail++;
            $display("FAIL scene_grant k=%0d got %b exp 10", k, grant_po);
          end
        end else if (g != 0 && i == g + 1) begin
          n_chk++;
          if (grant_po !== 2'b00 || b_po !== exp_b[k] || on_po !== 1'b1) begin
            n_fail++;
            $display("FAIL scene_pattern k=%0d got g=%b on=%b b=%b exp g=00 on=1 b=%b",
                     k, grant_po, on_po, b_po, exp_b[k]);
          end
        end
      end
      n_chk++;
      if (g == 0) begin
        n_fail++;
        $display("FAIL scene_no_grant k=%0d got none exp grant 10", k);
      end
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_first [2] = '{2'b01, 2'b10};
    logic [1:0] exp_second [2] = '{2'b10, 2'b01};
    test_reset();
    for (int r = 0; r < 2; r++) begin
      p1 = 1; p2 = 1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        n_chk++;
        if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
          n_fail++;
          $display("FAIL tie_model r=%0d cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                   r, i, grant_po, on_po, b_po, m_grant, m_on, m_b);
        end
        if (i == 11) begin
          p1 = 0; p2 = 0;
          n_chk++;
          if (grant_po !== exp_first[r]) begin
            n_fail++;
            $display("FAIL tie_first r=%0d got %b exp %b", r, grant_po, exp_first[r]);
          end
        end
        if (i == 12) begin
          n_chk++;
          if (grant_po !== exp_second[r]) begin
            n_fail++;
            $display("FAIL tie_second r=%0d got %b exp %b", r, grant_po, exp_second[r]);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int off_at = 0;
    test_reset();
    p1 = 1;
    for (int i = 1; i <= T + 30; i++) begin
      @(negedge clk);
      if (i == 11) p1 = 0;
      n_chk++;
      if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
        n_fail++;
        $display("FAIL timeout_model cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                 i, grant_po, on_po, b_po, m_grant, m_on, m_b);
      end
      if (i > 12 && on_po == 1'b0 && off_at == 0) off_at = i;
    end
    n_chk++;
    if (off_at != 12 + T || b_po !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_expiry got off_at=%0d b=%b exp off_at=%0d b=000", off_at, b_po, 12 + T);
    end
    test_reset();
    p1 = 1;
    for (int i = 1; i <= T + 20; i++) begin
      @(negedge clk);
      if (i == 11) p1 = 0;
      if (i == T) p2 = 1;
      n_chk++;
      if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
        n_fail++;
        $display("FAIL timeout_race_model cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                 i, grant_po, on_po, b_po, m_grant, m_on, m_b);
      end
      if (i == T + 11) begin
        p2 = 0;
        n_chk++;
        if (grant_po !== 2'b10) begin
          n_fail++;
          $display("FAIL timeout_race_grant got %b exp 10", grant_po);
        end
      end
      if (i == T + 12) begin
        n_chk++;
        if (on_po !== 1'b1 || b_po !== 3'b011) begin
          n_fail++;
          $display("FAIL timeout_race_keep_on got on=%b b=%b exp on=1 b=011", on_po, b_po);
        end
      end
    end
  endtask

  task automatic test_off_scene();
    test_reset();
    p2 = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 11) begin
        p2 = 0;
        n_chk++;
        if (grant_po !== 2'b10) begin
          n_fail++;
          $display("FAIL off_scene_grant got %b exp 10", grant_po);
        end
      end
      n_chk++;
      if (on_po !== 1'b0 || b_po !== 3'b000) begin
        n_fail++;
        $display("FAIL off_scene_dark cyc=%0d got on=%b b=%b exp on=0 b=000", i, on_po, b_po);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    p1 = 1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 11) p1 = 0;
    end
    n_chk++;
    if (on_po !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup got on=%b exp 1", on_po);
    end
    p1 = 1;
    repeat (5) @(negedge clk);
    rst = 1; p1 = 0;
    @(negedge clk);
    n_chk++;
    if ({grant_po, on_po, b_po} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got g=%b on=%b b=%b exp all 0", grant_po, on_po, b_po);
    end
    rst = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_chk++;
      if ({grant_po, on_po, b_po} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet cyc=%0d got g=%b on=%b b=%b exp all 0", i, grant_po, on_po, b_po);
      end
    end
  endtask

  task automatic test_random();
    int run1 = 0, run2 = 0;
    test_reset();
    for (int i = 0; i < 1500; i++) begin
      if (run1 == 0) begin p1 = ~p1; run1 = $urandom_range(1, 20); end
      if (run2 == 0) begin p2 = ~p2; run2 = $urandom_range(1, 20); end
      if ($urandom_range(0, 99) < 3) begin p1 = 0; p2 = 0; run1 = 90; run2 = 90; end
      run1--; run2--;
      @(negedge clk);
      n_chk++;
      if ({grant_po, on_po, b_po} !== {m_grant, m_on, m_b}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got g=%b on=%b b=%b exp g=%b on=%b b=%b",
                 i, grant_po, on_po, b_po, m_grant, m_on, m_b);
      end
    end
    p1 = 0; p2 = 0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_glitch();
    test_scene();
    test_tie();
    test_timeout();
    test_off_scene();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
